// File: rtl/ctrl_pipe_chain.sv
// Purpose : in-order control-word pipeline of DEPTH stages with per-stage stall and flush.
// Latency : DEPTH cycles from In_Data to Out_Data when nothing is held or flushed.
// Backpres: a stall on stage i freezes every stage upstream of it; Ready_In drops while stage 0 is held or flushed.
//
// Ports:
//   Clk, Reset            rising-edge clock, synchronous active-high reset
//   In_Data/In_Valid      word entering stage 0 (In_Valid=0 means bubble)
//   Stall/Flush [DEPTH]   per-stage hold request / replace-with-bubble request
//   Ready_In              stage 0 takes In_Data on this edge
//   Stage_Data/Valid      registered contents of every stage, stage i at [i*WIDTH +: WIDTH]
//   Out_Data/Out_Valid    last stage
//   Occupancy             number of valid stages
module ctrl_pipe_chain #(
    parameter int               WIDTH     = 13,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic [WIDTH-1:0]             In_Data,
    input  logic                         In_Valid,
    input  logic [DEPTH-1:0]             Stall,
    input  logic [DEPTH-1:0]             Flush,
    output logic                         Ready_In,
    output logic [DEPTH*WIDTH-1:0]       Stage_Data,
    output logic [DEPTH-1:0]             Stage_Valid,
    output logic [WIDTH-1:0]             Out_Data,
    output logic                         Out_Valid,
    output logic [$clog2(DEPTH+1)-1:0]   Occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] hold;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];

    // A stage must hold if it or any stage downstream of it is stalled;
    // otherwise it would overwrite a word that cannot move on.
    always_comb begin
        hold            = '0;
        hold[DEPTH-1]   = Stall[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) begin
            hold[i] = Stall[i] | hold[i+1];
        end
    end

    assign Ready_In = ~hold[0] & ~Flush[0];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            int  p;
            logic prev_hold;
            // p is only meaningful for i>0; clamped so stage 0 never indexes below the array.
            p         = (i > 0) ? i - 1 : 0;
            prev_hold = (i > 0) ? hold[p] : 1'b0;

            valid_d[i] = valid_q[i];
            data_d[i]  = data_q[i];
            if (Flush[i]) begin
                valid_d[i] = 1'b0;
                data_d[i]  = CLEAR_VAL;
            end else if (hold[i]) begin
                valid_d[i] = valid_q[i];
                data_d[i]  = data_q[i];
            end else if (i == 0) begin
                // Bubbles always carry CLEAR_VAL, whatever In_Data holds.
                valid_d[i] = In_Valid;
                data_d[i]  = In_Valid ? In_Data : CLEAR_VAL;
            end else if (prev_hold) begin
                // Upstream is frozen: insert a bubble so the held word is not duplicated.
                valid_d[i] = 1'b0;
                data_d[i]  = CLEAR_VAL;
            end else begin
                valid_d[i] = valid_q[p];
                data_d[i]  = data_q[p];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= CLEAR_VAL;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        Stage_Data = '0;
        Occupancy  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            Stage_Data[i*WIDTH +: WIDTH] = data_q[i];
            Occupancy = Occupancy + OCC_W'(valid_q[i]);
        end
    end

    assign Stage_Valid = valid_q;
    assign Out_Data    = data_q[DEPTH-1];
    assign Out_Valid   = valid_q[DEPTH-1];

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Purpose : self-checking bench for ctrl_pipe_chain (WIDTH=13, DEPTH=3).
// Latency : n/a.
// Backpres: n/a.
module tb_ctrl_pipe_chain;

    localparam int W = 13;
    localparam int D = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   in_dat;
    logic           in_vld;
    logic [D-1:0]   stall, flush;
    logic           ready_in;
    logic [D*W-1:0] stage_dat;
    logic [D-1:0]   stage_vld;
    logic [W-1:0]   out_dat;
    logic           out_vld;
    logic [1:0]     occ;

    ctrl_pipe_chain #(.WIDTH(W), .DEPTH(D), .CLEAR_VAL(13'h0)) dut (
        .Clk(clk), .Reset(rst), .In_Data(in_dat), .In_Valid(in_vld),
        .Stall(stall), .Flush(flush), .Ready_In(ready_in),
        .Stage_Data(stage_dat), .Stage_Valid(stage_vld),
        .Out_Data(out_dat), .Out_Valid(out_vld), .Occupancy(occ)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each slot is a (valid, word) pair. A slot is frozen when
    // any stall request exists at or beyond it; a flushed slot becomes empty; a
    // free slot behind a frozen one receives nothing.
    bit           m_v [D];
    logic [W-1:0] m_d [D];

    always @(posedge clk) begin
        bit           nv [D];
        logic [W-1:0] nd [D];
        if (rst) begin
            for (int s = 0; s < D; s++) begin nv[s] = 0; nd[s] = '0; end
            chk_en = 1'b1;
        end else begin
            for (int s = 0; s < D; s++) begin
                bit frozen, up_frozen;
                frozen    = (stall >> s) != 0;
                up_frozen = (s > 0) && ((stall >> (s - 1)) != 0);
                if (flush[s])        begin nv[s] = 0; nd[s] = '0; end
                else if (frozen)     begin nv[s] = m_v[s]; nd[s] = m_d[s]; end
                else if (s == 0)     begin nv[s] = in_vld; nd[s] = in_vld ? in_dat : '0; end
                else if (up_frozen)  begin nv[s] = 0; nd[s] = '0; end
                else                 begin nv[s] = m_v[s-1]; nd[s] = m_d[s-1]; end
            end
        end
        m_v = nv;
        m_d = nd;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int cnt;
            cnt = 0;
            for (int s = 0; s < D; s++) begin
                chk($sformatf("model_vld%0d", s), 32'(stage_vld[s]), 32'(m_v[s]));
                chk($sformatf("model_dat%0d", s), 32'(stage_dat[s*W +: W]), 32'(m_d[s]));
                cnt += int'(m_v[s]);
            end
            chk("model_out_dat", 32'(out_dat), 32'(m_d[D-1]));
            chk("model_out_vld", 32'(out_vld), 32'(m_v[D-1]));
            chk("model_occ", 32'(occ), 32'(cnt));
            if (!rst)
                chk("model_ready", 32'(ready_in), 32'(stall == '0 && !flush[0]));
        end
    end

    task automatic drive(input bit r, input logic [D-1:0] st, input logic [D-1:0] fl,
                         input bit v, input logic [W-1:0] d);
        rst = r; stall = st; flush = fl; in_vld = v; in_dat = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [W-1:0] A = 13'h0A1;
    localparam logic [W-1:0] B = 13'h0B2;
    localparam logic [W-1:0] C = 13'h0C3;

    // Leaves stage0=A, stage1=B, stage2=C.
    task automatic fill_abc();
        drive(0, 3'b000, 3'b000, 1, C); tick();
        drive(0, 3'b000, 3'b000, 1, B); tick();
        drive(0, 3'b000, 3'b000, 1, A); tick();
    endtask

    function automatic logic [W-1:0] sd(input int s);
        return stage_dat[s*W +: W];
    endfunction

    initial begin
        drive(1, 3'b000, 3'b000, 0, '0);
        tick(); tick();
        chk("rst_vld", 32'(stage_vld), 32'h0);
        chk("rst_out", 32'(out_dat), 32'h0);
        chk("rst_occ", 32'(occ), 32'h0);

        // Streaming 1,2,3,4
        drive(0, 3'b000, 3'b000, 1, 13'd1); tick();
        drive(0, 3'b000, 3'b000, 1, 13'd2); tick();
        drive(0, 3'b000, 3'b000, 1, 13'd3); tick();
        chk("stream_c3_out", 32'(out_dat), 32'd1);
        chk("stream_c3_vld", 32'(out_vld), 32'd1);
        chk("stream_c3_occ", 32'(occ), 32'd3);
        drive(0, 3'b000, 3'b000, 1, 13'd4); tick();
        chk("stream_c4_out", 32'(out_dat), 32'd2);
        drive(0, 3'b000, 3'b000, 0, 13'h1FFF); tick();
        chk("stream_c5_out", 32'(out_dat), 32'd3);
        tick();
        chk("stream_c6_out", 32'(out_dat), 32'd4);
        chk("stream_c6_vld", 32'(out_vld), 32'd1);
        chk("stream_bubble_dat0", 32'(sd(0)), 32'h0);

        // Load-use
        fill_abc();
        drive(0, 3'b001, 3'b010, 1, 13'h555); #1;
        chk("lu_ready", 32'(ready_in), 32'd0);
        tick();
        chk("lu_s0", 32'(sd(0)), 32'(A));
        chk("lu_s1_vld", 32'(stage_vld[1]), 32'd0);
        chk("lu_s1_dat", 32'(sd(1)), 32'h0);
        chk("lu_s2", 32'(sd(2)), 32'(B));

        // Back-propagated stall
        fill_abc();
        for (int c = 0; c < 2; c++) begin
            drive(0, 3'b100, 3'b000, 1, 13'h777); #1;
            chk("bp_ready", 32'(ready_in), 32'd0);
            tick();
            chk("bp_vld", 32'(stage_vld), 32'h7);
            chk("bp_data", 32'(stage_dat), 32'({C, B, A}));
        end

        // Mid-pipe stall
        fill_abc();
        drive(0, 3'b010, 3'b000, 1, 13'h666); #1;
        chk("mid_ready", 32'(ready_in), 32'd0);
        tick();
        chk("mid_vld", 32'(stage_vld), 32'b011);
        chk("mid_data", 32'(stage_dat), 32'({13'h0, B, A}));

        // Flush together with hold on the last stage
        fill_abc();
        drive(0, 3'b100, 3'b100, 1, 13'h444); tick();
        chk("fh_vld", 32'(stage_vld), 32'b011);
        chk("fh_data", 32'(stage_dat), 32'({13'h0, B, A}));

        // Reset mid-stream
        fill_abc();
        drive(1, 3'b001, 3'b000, 1, 13'h333); tick();
        chk("rms_vld", 32'(stage_vld), 32'h0);
        chk("rms_out", 32'(out_dat), 32'h0);
        for (int c = 0; c < 4; c++) begin
            drive(0, 3'b000, 3'b000, 0, '0); tick();
            chk("rms_no_old_out", 32'(out_vld), 32'd0);
        end

        // Mixed stall/flush traffic, checked against the model every cycle
        for (int c = 0; c < 300; c++) begin
            logic [D-1:0] st, fl;
            st = ($urandom_range(0, 3) == 0) ? D'($urandom) : '0;
            fl = ($urandom_range(0, 4) == 0) ? D'($urandom) : '0;
            drive(($urandom_range(0, 60) == 0), st, fl, 1'($urandom),
                  W'($urandom_range(1, 8191)));
            tick();
        end

        drive(0, 3'b000, 3'b000, 0, '0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
